// File: rtl/store_pkg.sv
// Shared definitions for the store read-modify-write path: width codes,
// FSM state encoding and width-classification helpers.
package store_pkg;

    // Width codes, same encoding as the load extender.
    localparam logic [2:0] MODE_WORD   = 3'b000;
    localparam logic [2:0] MODE_BYTE_S = 3'b001;
    localparam logic [2:0] MODE_BYTE_U = 3'b010;
    localparam logic [2:0] MODE_HALF_S = 3'b011;
    localparam logic [2:0] MODE_HALF_U = 3'b100;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        FAULT = 3'd4
    } state_t;

    function automatic logic is_byte(input logic [2:0] mode);
        return (mode == MODE_BYTE_S) || (mode == MODE_BYTE_U);
    endfunction

    function automatic logic is_half(input logic [2:0] mode);
        return (mode == MODE_HALF_S) || (mode == MODE_HALF_U);
    endfunction

    // Unlisted codes fall back to word, so only byte and half are sub-word.
    function automatic logic is_subword(input logic [2:0] mode);
        return is_byte(mode) || is_half(mode);
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: places a byte or half of new_data into its lane
// of old_word; word stores pass new_data through unchanged.
module store_lane_merge
    import store_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [2:0]  mode,
    input  logic [1:0]  offset,
    output logic [31:0] merged_word
);

    // Select the target lane from the byte offset and overlay the new data.
    always_comb begin
        merged_word = new_data;
        if (is_byte(mode)) begin
            merged_word = old_word;
            case (offset)
                2'd0: merged_word[7:0]   = new_data[7:0];
                2'd1: merged_word[15:8]  = new_data[7:0];
                2'd2: merged_word[23:16] = new_data[7:0];
                2'd3: merged_word[31:24] = new_data[7:0];
                default: merged_word = old_word;
            endcase
        end else if (is_half(mode)) begin
            merged_word = old_word;
            if (offset[1]) begin
                merged_word[31:16] = new_data[15:0];
            end else begin
                merged_word[15:0] = new_data[15:0];
            end
        end
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit for a word-only data RAM. Word stores are written directly;
// byte and half stores read the word, merge the new lane and write it back.
// Optional: define MISALIGN_TRAP_EN to trap misaligned half/word stores
// (done+err pulse, memory untouched) instead of ignoring low address bits.
module store_rmw_unit
    import store_pkg::*;
#(
    parameter int MEM_RD_LAT = 1,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [2:0]        req_mode,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] LAT_M1 = 2'(MEM_RD_LAT - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [31:0]       old_q;
    logic [2:0]        mode_q;
    logic [1:0]        wait_cnt;
    logic [31:0]       merged;
    logic              accept;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

`ifdef MISALIGN_TRAP_EN
    logic req_misaligned;
    assign req_misaligned = (is_half(req_mode) && req_addr[0]) ||
                            (!is_subword(req_mode) && (req_addr[1:0] != 2'b00));
`endif

    store_lane_merge u_merge (
        .old_word    (old_q),
        .new_data    (data_q),
        .mode        (mode_q),
        .offset      (addr_q[1:0]),
        .merged_word (merged)
    );

    // Request latch, read-latency counter and store sequencing FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            mode_q   <= '0;
            old_q    <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q <= req_addr;
                        data_q <= req_data;
                        mode_q <= req_mode;
`ifdef MISALIGN_TRAP_EN
                        if (req_misaligned) state <= FAULT;
                        else
`endif
                        if (is_subword(req_mode)) state <= READ;
                        else                      state <= WRITE;
                    end
                end
                READ: begin
                    wait_cnt <= LAT_M1;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        old_q <= mem_rdata;
                        state <= WRITE;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                WRITE: state <= IDLE;
`ifdef MISALIGN_TRAP_EN
                FAULT: state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode directly from state so reset removes them at once.
    assign mem_addr  = addr_q[ADDR_W-1:2];
    assign mem_re    = (state == READ);
    assign mem_we    = (state == WRITE);
    assign mem_wdata = (state == WRITE) ? merged : '0;

`ifdef MISALIGN_TRAP_EN
    assign done = (state == WRITE) || (state == FAULT);
    assign err  = (state == FAULT);
`else
    assign done = (state == WRITE);
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed self-checking bench for store_rmw_unit. Instance dut uses a
// three-cycle read latency, dut1 a one-cycle latency; each has its own
// word memory model. Compile with the same MISALIGN_TRAP_EN setting as RTL.
module tb_store_rmw_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid1;
    logic [31:0] req_addr, req_data;
    logic [2:0]  req_mode;

    logic        req_ready, mem_re, mem_we, done, err;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata, mem_wdata;

    logic        req_ready1, mem_re1, mem_we1, done1, err1;
    logic [29:0] mem_addr1;
    logic [31:0] mem_rdata1, mem_wdata1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_rmw_unit #(.MEM_RD_LAT(3), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_mode(req_mode),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .done(done), .err(err)
    );

    store_rmw_unit #(.MEM_RD_LAT(1), .ADDR_W(32)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_addr(req_addr), .req_data(req_data), .req_mode(req_mode),
        .mem_addr(mem_addr1), .mem_re(mem_re1), .mem_rdata(mem_rdata1),
        .mem_we(mem_we1), .mem_wdata(mem_wdata1), .done(done1), .err(err1)
    );

    // Memory models: read data appears MEM_RD_LAT cycles after mem_re,
    // undefined otherwise so a mistimed capture shows up as X.
    logic [31:0] mem  [0:255];
    logic [31:0] mem1 [0:255];
    logic [31:0] rp0, rp1, rp2, rq1;
    int we_cnt = 0, re_cnt = 0, both_cnt = 0;

    assign mem_rdata  = rp2;
    assign mem_rdata1 = rq1;

    always @(posedge clk) begin
        rp0 <= mem_re ? mem[mem_addr[7:0]] : 32'hxxxxxxxx;
        rp1 <= rp0;
        rp2 <= rp1;
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_we) we_cnt <= we_cnt + 1;
        if (mem_re) re_cnt <= re_cnt + 1;
        if ((mem_re && mem_we) || (mem_re1 && mem_we1)) both_cnt <= both_cnt + 1;
        rq1 <= mem_re1 ? mem1[mem_addr1[7:0]] : 32'hxxxxxxxx;
        if (mem_we1) mem1[mem_addr1[7:0]] <= mem_wdata1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
        req_addr = a; req_data = d; req_mode = m; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic issue1(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
        req_addr = a; req_data = d; req_mode = m; req_valid1 = 1'b1;
        @(posedge clk);
        #1;
        req_valid1 = 1'b0;
    endtask

    task automatic test_reset();
        int w0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", req_ready); end
        checks++; if ({done, err, mem_re, mem_we} !== 4'b0000) begin errors++; $display("FAIL rst_strobes got %b want 0000", {done, err, mem_re, mem_we}); end
        checks++; if (mem_addr !== 30'h0) begin errors++; $display("FAIL rst_addr got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", mem_wdata); end
        w0 = we_cnt;
        issue(32'h100, 32'h77, 3'b001);
        checks++; if (mem_re !== 1'b1) begin errors++; $display("FAIL rst_pre_re got %b want 1", mem_re); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({mem_re, mem_we, done} !== 3'b000) begin errors++; $display("FAIL rst_mid got %b want 000", {mem_re, mem_we, done}); end
        tick(); tick();
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rst_release got ready=%b done=%b want 1 0", req_ready, done); end
        repeat (6) tick();
        checks++; if (we_cnt !== w0) begin errors++; $display("FAIL rst_nowrite got %0d writes want %0d", we_cnt, w0); end
    endtask

    task automatic test_idle();
        int w0, r0;
        w0 = we_cnt; r0 = re_cnt;
        repeat (5) begin
            tick();
            checks++; if (done !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL idle got done=%b ready=%b want 0 1", done, req_ready); end
        end
        checks++; if (we_cnt !== w0 || re_cnt !== r0) begin errors++; $display("FAIL idle_strobes got we=%0d re=%0d want %0d %0d", we_cnt, re_cnt, w0, r0); end
    endtask

    task automatic test_word();
        int r0;
        r0 = re_cnt;
        issue(32'h100, 32'hDEADBEEF, 3'b000);
        checks++; if ({mem_we, done, err, mem_re} !== 4'b1100) begin errors++; $display("FAIL word_strobes got %b want 1100", {mem_we, done, err, mem_re}); end
        checks++; if (mem_addr !== 30'h40) begin errors++; $display("FAIL word_addr got %h want 40", mem_addr); end
        checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL word_wdata got %h want deadbeef", mem_wdata); end
        tick();
        checks++; if (req_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL word_after got ready=%b done=%b want 1 0", req_ready, done); end
        checks++; if (mem[8'h40] !== 32'hDEADBEEF) begin errors++; $display("FAIL word_mem got %h want deadbeef", mem[8'h40]); end
        checks++; if (re_cnt !== r0) begin errors++; $display("FAIL word_noread got %0d reads want %0d", re_cnt, r0); end
    endtask

    task automatic test_byte_lat1();
        mem1[8'h40] = 32'h11223344;
        issue1(32'h102, 32'h000000AB, 3'b001);
        checks++; if ({mem_re1, mem_we1} !== 2'b10) begin errors++; $display("FAIL byte_t1 got re,we=%b want 10", {mem_re1, mem_we1}); end
        checks++; if (mem_addr1 !== 30'h40) begin errors++; $display("FAIL byte_addr got %h want 40", mem_addr1); end
        tick();
        checks++; if ({mem_re1, mem_we1, done1} !== 3'b000) begin errors++; $display("FAIL byte_t2 got %b want 000", {mem_re1, mem_we1, done1}); end
        tick();
        checks++; if ({mem_we1, done1, err1} !== 3'b110) begin errors++; $display("FAIL byte_t3 got we,done,err=%b want 110", {mem_we1, done1, err1}); end
        checks++; if (mem_wdata1 !== 32'h11AB3344) begin errors++; $display("FAIL byte_wdata got %h want 11ab3344", mem_wdata1); end
        tick();
        checks++; if (mem1[8'h40] !== 32'h11AB3344 || req_ready1 !== 1'b1) begin errors++; $display("FAIL byte_after got mem=%h ready=%b want 11ab3344 1", mem1[8'h40], req_ready1); end
    endtask

    task automatic test_half();
        mem[8'h3F] = 32'hCAFEBABE;
        issue(32'h0FE, 32'h00001234, 3'b100);
        for (int k = 1; k <= 5; k++) begin
            checks++; if (mem_addr !== 30'h3F) begin errors++; $display("FAIL half_addr t%0d got %h want 3f", k, mem_addr); end
            checks++; if (done !== (k == 5) || mem_we !== (k == 5) || mem_re !== (k == 1)) begin
                errors++; $display("FAIL half_seq t%0d got done=%b we=%b re=%b", k, done, mem_we, mem_re);
            end
            if (k == 5) begin
                checks++; if (mem_wdata !== 32'h1234BABE) begin errors++; $display("FAIL half_wdata got %h want 1234babe", mem_wdata); end
            end else begin
                tick();
            end
        end
        tick();
        checks++; if (mem[8'h3F] !== 32'h1234BABE) begin errors++; $display("FAIL half_mem got %h want 1234babe", mem[8'h3F]); end
    endtask

    task automatic test_misalign();
        int w0;
        w0 = we_cnt;
        issue(32'h101, 32'h00005678, 3'b011);
`ifdef MISALIGN_TRAP_EN
        checks++; if ({done, err, mem_we, mem_re} !== 4'b1100) begin errors++; $display("FAIL mis_trap got done,err,we,re=%b want 1100", {done, err, mem_we, mem_re}); end
        tick();
        checks++; if (req_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mis_after got ready=%b done=%b err=%b", req_ready, done, err); end
        checks++; if (we_cnt !== w0 || mem[8'h40] !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_mem got writes=%0d mem=%h want %0d deadbeef", we_cnt, mem[8'h40], w0); end
`else
        repeat (4) tick();
        checks++; if ({done, err, mem_we} !== 3'b101) begin errors++; $display("FAIL mis_done got done,err,we=%b want 101", {done, err, mem_we}); end
        checks++; if (mem_wdata !== 32'hDEAD5678 || mem_addr !== 30'h40) begin errors++; $display("FAIL mis_wdata got %h @%h want dead5678 @40", mem_wdata, mem_addr); end
        tick();
        checks++; if (we_cnt !== w0 + 1) begin errors++; $display("FAIL mis_writes got %0d want %0d", we_cnt, w0 + 1); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        mem[8'h80] = 32'h0;
        req_addr = 32'h200; req_data = 32'hAA; req_mode = 3'b001; req_valid = 1'b1;
        tick();
        req_addr = 32'h201; req_data = 32'hBB;
        repeat (4) tick();
        checks++; if (done !== 1'b1 || req_ready !== 1'b0 || mem_wdata !== 32'h000000AA) begin
            errors++; $display("FAIL b2b_first got done=%b ready=%b wdata=%h want 1 0 000000aa", done, req_ready, mem_wdata);
        end
        tick();
        checks++; if (req_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_gap got ready=%b done=%b want 1 0", req_ready, done); end
        tick();
        req_valid = 1'b0;
        checks++; if (mem_re !== 1'b1 || mem_addr !== 30'h80) begin errors++; $display("FAIL b2b_accept got re=%b addr=%h want 1 80", mem_re, mem_addr); end
        repeat (4) tick();
        checks++; if (done !== 1'b1 || mem_wdata !== 32'h0000BBAA) begin errors++; $display("FAIL b2b_second got done=%b wdata=%h want 1 0000bbaa", done, mem_wdata); end
        tick();
        w = mem[8'h80];
        checks++; if (w[15:0] !== 16'hBBAA) begin errors++; $display("FAIL b2b_mem got %h want bbaa", w[15:0]); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_valid1 = 1'b0;
        req_addr = '0; req_data = '0; req_mode = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            mem1[i] = '0;
        end
        test_reset();
        test_idle();
        test_word();
        test_byte_lat1();
        test_half();
        test_misalign();
        test_back_to_back();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL re_we_overlap got %0d cycles want 0", both_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Store-side counterpart of the load extender. Takes CPU store requests (word, half or byte) and writes them into a word-only data memory that has no byte enables.
- Word stores go straight to memory.
- Sub-word stores run read-modify-write: read the word, merge the byte or half into its lane, write the word back.
- Sits between the MEM stage and the data RAM; the pipeline stalls on req_ready.

Parameters:
- MEM_RD_LAT, 1, cycles from mem_re to valid mem_rdata; legal range 1..4.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit idle; request accepted when req_valid && req_ready.
- req_addr  in  ADDR_W  byte address.
- req_data  in  32  store data, right-justified.
- req_mode  in  3  width code, same encoding as the load extender.
  - 000: word.
  - 001 or 010: byte.
  - 011 or 100: half.
  - others: word.
- mem_addr  out  ADDR_W-2  word address.
- mem_re  out  1  read strobe.
- mem_rdata  in  32  read data.
- mem_we  out  1  write strobe.
- mem_wdata  out  32  merged write word.
- done  out  1  one-cycle pulse when the store completes.
- err  out  1  misalign flag, valid with done.

Behaviour:
- Reset (async): state IDLE; mem_re, mem_we, done, err = 0; mem_addr, mem_wdata, latched registers = 0. req_ready = 1 once rst is released.
- Acceptance:
  - req_ready = (state == IDLE), combinational from state.
  - On acceptance, latch req_addr, req_data and req_mode; request inputs are don't-care afterwards.
- States:
  - IDLE:
    - word request -> WRITE;
    - sub-word request -> READ;
    - misaligned request (MISALIGN_TRAP_EN only) -> FAULT.
  - READ: mem_re = 1 for exactly one cycle, mem_addr = addr[ADDR_W-1:2]; go to WAIT; load wait counter with MEM_RD_LAT-1.
  - WAIT:
    - counter decrements each cycle;
    - when it reaches 0, capture mem_rdata into the old-word register and go to WRITE.
    - With MEM_RD_LAT = 1, WAIT lasts one cycle and captures immediately.
  - WRITE: mem_we = 1, done = 1, err = 0, mem_wdata = merged word; go to IDLE.
  - FAULT: done = 1, err = 1, no memory access; go to IDLE.
- Latency from accept edge T:
  - word: done at T+1.
  - sub-word: done at T+2+MEM_RD_LAT.
  - Next request can be accepted in the cycle after done.
- Merge rules:
  - byte: lane addr[1:0] gets req_data[7:0]; other three bytes come from the old word.
  - half: lane addr[1] (bits 15:0 or 31:16) gets req_data[15:0]; other half comes from the old word.
  - word: mem_wdata = req_data; the old word is unused.
- mem_re and mem_we are never high in the same cycle; mem_addr is held constant from READ through WRITE.
- Back-to-back: after a write to address A, a following sub-word store to A reads the updated word. Memory is write-before-read across cycles; the unit does no forwarding.
- Reset mid-operation: strobes and done drop immediately, no partial write is issued, return to IDLE.
- req_valid low in IDLE: outputs idle, no strobes.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - half with addr[0] = 1, or word with addr[1:0] != 0, goes to FAULT: one-cycle done+err, memory untouched.
- Undefined:
  - offending low address bits are ignored (half uses lane addr[1]; word uses addr[ADDR_W-1:2]);
  - err is tied to 0 and the FAULT state is absent.

Decomposition:
- Package store_pkg:
  - mode constants MODE_WORD, MODE_BYTE_S, MODE_BYTE_U, MODE_HALF_S, MODE_HALF_U;
  - state enum {IDLE, READ, WAIT, WRITE, FAULT};
  - function is_subword(mode).
- Sub-module store_lane_merge: purely combinational (old_word, new_data, mode, offset) -> merged_word. Shared by the FSM and reusable by a future store buffer.

Test Plan:
- Reset: rst=1 mid-READ -> mem_re=0 immediately; after release req_ready=1, done=0, no write issued.
- Word store: addr=0x100, data=0xDEADBEEF, mode=000 -> mem_we at T+1, mem_addr=0x40, mem_wdata=0xDEADBEEF, done=1, mem_re never asserted.
- Byte store, MEM_RD_LAT=1: memory word 0x11223344 at 0x100; store addr=0x102, data=0x000000AB, mode=001 -> mem_re at T+1, mem_we at T+3 with wdata=0x11AB3344.
- Half store, MEM_RD_LAT=3: old word 0xCAFEBABE; addr=0x0FE, data=0x1234, mode=100 -> done at T+5, wdata=0x1234BABE, mem_addr=0x3F throughout.
- Misaligned half, addr=0x101:
  - with MISALIGN_TRAP_EN: done=err=1 at T+1, no mem_we;
  - without: treated as lane 0, err=0.
- Back-to-back: byte stores 0xAA to 0x200 then 0xBB to 0x201, req_valid held high -> second accepted the cycle after the first done; final word low half = 0xBBAA.
